// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: mode codes, legality check
// and the arbiter state encoding.
package alu_pkg;

    localparam logic [3:0] MODE_ADD = 4'b0000;
    localparam logic [3:0] MODE_SUB = 4'b0001;
    localparam logic [3:0] MODE_AND = 4'b0011;
    localparam logic [3:0] MODE_OR  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Only the four codes the ALU implements are accepted.
    function automatic logic is_legal_mode(input logic [3:0] mode);
        logic legal;
        case (mode)
            MODE_ADD, MODE_SUB, MODE_AND, MODE_OR: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester-side and ALU-side signals around the arbiter.
// slave = arbiter view, master = environment (requesters + ALU) view.
interface alu_req_arbiter_if;

    logic [1:0]      req;
    logic [1:0][3:0] op_a;
    logic [1:0][3:0] op_b;
    logic [1:0][3:0] op_mode;
    logic [1:0]      gnt;
    logic [1:0]      ack;
    logic            busy;
    logic [7:0]      rsp_result;
    logic            rsp_neg;
    logic            rsp_cero;
    logic            rsp_carry;
    logic            rsp_err;
    logic [3:0]      alu_in1;
    logic [3:0]      alu_in2;
    logic [3:0]      alu_mode;
    logic [7:0]      alu_num;
    logic            alu_neg;
    logic            alu_cero;
    logic            alu_carry;

    modport slave (
        input  req, op_a, op_b, op_mode, alu_num, alu_neg, alu_cero, alu_carry,
        output gnt, ack, busy, rsp_result, rsp_neg, rsp_cero, rsp_carry, rsp_err,
               alu_in1, alu_in2, alu_mode
    );

    modport master (
        output req, op_a, op_b, op_mode, alu_num, alu_neg, alu_cero, alu_carry,
        input  gnt, ack, busy, rsp_result, rsp_neg, rsp_cero, rsp_carry, rsp_err,
               alu_in1, alu_in2, alu_mode
    );

endinterface

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On a tie the requester that did not win last
// time is chosen; the pointer only moves when enabled and a grant is made.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic       o_valid,
    output logic       o_idx
);

    logic r_last;

    // Pick a winner from the current requests and the last pointer.
    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) begin
            o_idx = ~r_last;
        end else begin
            o_idx = i_req[1];
        end
    end

    // Remember who won; reset leaves last=1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_en && o_valid) begin
            r_last <= o_idx;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters. A granted request is
// registered, driven to the ALU for SETTLE_CYCLES cycles, captured, and
// returned with a one-cycle ack. Illegal modes are answered without using
// the ALU.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_req_arbiter_if.slave  bus
);

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    arb_state_t r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_gnt;
    logic [1:0] r_ack;
    logic       r_busy;
    logic [7:0] r_result;
    logic       r_neg;
    logic       r_cero;
    logic       r_carry;
    logic       r_err;
    logic [3:0] r_in1;
    logic [3:0] r_in2;
    logic [3:0] r_mode;

    logic       w_valid;
    logic       w_idx;
    logic [1:0] w_onehot;
    logic       w_legal;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_state == IDLE),
        .i_req   (bus.req),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_onehot = w_idx ? 2'b10 : 2'b01;
    assign w_legal  = is_legal_mode(bus.op_mode[w_idx]);

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_gnt    <= 2'b00;
            r_ack    <= 2'b00;
            r_busy   <= 1'b0;
            r_result <= 8'h00;
            r_neg    <= 1'b0;
            r_cero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_in1    <= 4'd0;
            r_in2    <= 4'd0;
            r_mode   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt  <= w_onehot;
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            // These registers are the operand copies the ALU sees.
                            r_state <= ISSUE;
                            r_cnt   <= 4'd0;
                            r_in1   <= bus.op_a[w_idx];
                            r_in2   <= bus.op_b[w_idx];
                            r_mode  <= bus.op_mode[w_idx];
                        end else begin
                            r_state  <= RESP;
                            r_ack    <= w_onehot;
                            r_result <= 8'h00;
                            r_neg    <= 1'b0;
                            r_cero   <= 1'b0;
                            r_carry  <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state  <= RESP;
                        r_cnt    <= 4'd0;
                        r_ack    <= r_gnt;
                        r_result <= bus.alu_num;
                        r_neg    <= bus.alu_neg;
                        r_cero   <= bus.alu_cero;
                        r_carry  <= bus.alu_carry;
                        r_err    <= 1'b0;
                        r_in1    <= 4'd0;
                        r_in2    <= 4'd0;
                        r_mode   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ack   <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.ack        = r_ack;
    assign bus.busy       = r_busy;
    assign bus.rsp_result = r_result;
    assign bus.rsp_neg    = r_neg;
    assign bus.rsp_cero   = r_cero;
    assign bus.rsp_carry  = r_carry;
    assign bus.rsp_err    = r_err;
    assign bus.alu_in1    = r_in1;
    assign bus.alu_in2    = r_in2;
    assign bus.alu_mode   = r_mode;

endmodule
